// File: rtl/htif_pkg.sv
// Shared definitions for the HTIF host responder: mailbox field codes,
// FSM state encoding, the decoded tohost word layout and the ack builder.
package htif_pkg;

    localparam logic [7:0] DEV_SYS     = 8'd0;
    localparam logic [7:0] DEV_CONSOLE = 8'd1;
    localparam logic [7:0] CMD_EXIT    = 8'd0;
    localparam logic [7:0] CMD_PUTCHAR = 8'd1;

    // Fixed encodings so older netlists and probes keep their state values.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_CONSOLE = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_DECODE  = S_DECODE,
        ST_CONSOLE = S_CONSOLE,
        ST_ACK     = S_ACK,
        ST_CLEAR   = S_CLEAR
    } htif_state_e;

    typedef struct packed {
        logic [7:0]  dev;
        logic [7:0]  cmd;
        logic [47:0] payload;
    } htif_cmd_t;

    function automatic logic [63:0] make_ack(input logic [7:0] dev, input logic [7:0] cmd);
        return {dev, cmd, 48'h0};
    endfunction

endpackage

// File: rtl/htif_ack_timer.sv
// Ack timeout strobe: a down-counter loaded with ACK_TIMEOUT-1 when the ack
// phase starts, firing while running with the count at zero.
// ACK_TIMEOUT == 0 removes the counter entirely and never fires.
module htif_ack_timer #(
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    if (ACK_TIMEOUT == 0) begin : g_bypass
        logic unused_timer;
        assign unused_timer = &{1'b0, clock, reset, load_i, run_i};
        assign expire_o     = 1'b0;
    end else begin : g_count
        localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACK_TIMEOUT - 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Next count: reload on ack entry, otherwise count down toward zero.
        always_comb begin
            cnt_d = cnt_q;
            if (load_i) begin
                cnt_d = LOAD_VAL;
            end else if (run_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Counter register.
        always_ff @(posedge clock) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign expire_o = run_i && (cnt_q == '0);
    end

endmodule

// File: rtl/htif_host_responder.sv
// Host side of the tohost/fromhost HTIF mailbox. Decodes tohost writes,
// serves console putchar and exit, acks putchar through fromhost and asks
// for tohost to be cleared after every command. exit_valid and error are
// sticky until reset. Only a 64-bit mailbox word is supported.
// Optional build macro HTIF_STATS_EN adds cmd_count, putchar_count and
// ack_stall_max statistics outputs.
//
// state   | meaning
// IDLE    | waiting for a tohost write (unless halted by exit)
// DECODE  | one cycle to classify the latched command
// CONSOLE | presenting the character until the sink takes it
// ACK     | presenting the fromhost ack until taken or timed out
// CLEAR   | one-cycle request to zero tohost
module htif_host_responder
    import htif_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned TOHOST_W    = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tohost_wr_valid,
    input  logic [TOHOST_W-1:0] tohost_wr_data,
    output logic                tohost_wr_ready,
    output logic                tohost_clear,
    output logic                console_valid,
    output logic [7:0]          console_char,
    input  logic                console_ready,
    output logic                fromhost_valid,
    output logic [TOHOST_W-1:0] fromhost_data,
    input  logic                fromhost_ready,
    output logic                exit_valid,
    output logic [46:0]         exit_code,
    output logic                error,
`ifdef HTIF_STATS_EN
    output logic [31:0]         cmd_count,
    output logic [31:0]         putchar_count,
    output logic [15:0]         ack_stall_max,
`endif
    output logic                busy
);

    htif_state_e state_q, state_d;
    htif_cmd_t   cmd_q, cmd_d;
    logic        exit_valid_q, exit_valid_d;
    logic [46:0] exit_code_q, exit_code_d;
    logic        error_q, error_d;

    logic accept;
    logic console_hs;
    logic ack_timeout;

    // Ready is also held low while reset is asserted so every output reads 0.
    assign tohost_wr_ready = reset && (state_q == ST_IDLE) && !exit_valid_q;
    assign accept          = tohost_wr_valid && tohost_wr_ready;
    assign console_hs      = (state_q == ST_CONSOLE) && console_ready;

    htif_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clock    (clock),
        .reset    (reset),
        .load_i   (console_hs),
        .run_i    (state_q == ST_ACK),
        .expire_o (ack_timeout)
    );

    // Command sequencing and sticky status updates.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        error_d      = error_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_d   = htif_cmd_t'(tohost_wr_data);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if ((cmd_q.dev == DEV_SYS) && (cmd_q.cmd == CMD_EXIT) && cmd_q.payload[0]) begin
                    exit_valid_d = 1'b1;
                    exit_code_d  = cmd_q.payload[47:1];
                    state_d      = ST_CLEAR;
                end else if ((cmd_q.dev == DEV_CONSOLE) && (cmd_q.cmd == CMD_PUTCHAR)) begin
                    state_d = ST_CONSOLE;
                end else begin
                    // Includes tohost==0 and syscall pointers, which this host does not serve.
                    error_d = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CONSOLE: begin
                if (console_ready) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // An ack taken on the expiry cycle still counts as delivered.
                if (fromhost_ready) begin
                    state_d = ST_CLEAR;
                end else if (ack_timeout) begin
                    error_d = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
            error_q      <= error_d;
        end
    end

    assign console_valid  = (state_q == ST_CONSOLE);
    assign console_char   = console_valid ? cmd_q.payload[7:0] : 8'h00;
    assign fromhost_valid = (state_q == ST_ACK);
    assign fromhost_data  = fromhost_valid ? make_ack(DEV_CONSOLE, CMD_PUTCHAR) : '0;
    assign tohost_clear   = (state_q == ST_CLEAR);
    assign exit_valid     = exit_valid_q;
    assign exit_code      = exit_code_q;
    assign error          = error_q;
    assign busy           = (state_q != ST_IDLE);

`ifdef HTIF_STATS_EN
    logic [31:0] cmd_count_q, cmd_count_d;
    logic [31:0] putchar_count_q, putchar_count_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] stall_max_q, stall_max_d;

    // Saturating statistics; the stall length restarts on each ack entry.
    always_comb begin
        cmd_count_d     = cmd_count_q;
        putchar_count_d = putchar_count_q;
        stall_d         = stall_q;
        if (accept && (cmd_count_q != 32'hFFFF_FFFF)) begin
            cmd_count_d = cmd_count_q + 32'd1;
        end
        if (console_hs && (putchar_count_q != 32'hFFFF_FFFF)) begin
            putchar_count_d = putchar_count_q + 32'd1;
        end
        if (console_hs) begin
            stall_d = 16'd0;
        end else if ((state_q == ST_ACK) && !fromhost_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        stall_max_d = (stall_d > stall_max_q) ? stall_d : stall_max_q;
    end

    // Statistics registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cmd_count_q     <= '0;
            putchar_count_q <= '0;
            stall_q         <= '0;
            stall_max_q     <= '0;
        end else begin
            cmd_count_q     <= cmd_count_d;
            putchar_count_q <= putchar_count_d;
            stall_q         <= stall_d;
            stall_max_q     <= stall_max_d;
        end
    end

    assign cmd_count     = cmd_count_q;
    assign putchar_count = putchar_count_q;
    assign ack_stall_max = stall_max_q;
`endif

endmodule

// File: tb/tb_htif_host_responder.sv
// Directed bench for htif_host_responder with a transaction-level model
// checked on every falling edge, plus hand-computed literal expectations.
module tb_htif_host_responder;

    localparam int TMO = 8;
    localparam logic [63:0] ACK_WORD = 64'h0101_0000_0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tohost_wr_valid = 1'b0;
    logic [63:0] tohost_wr_data = '0;
    logic        tohost_wr_ready;
    logic        tohost_clear;
    logic        console_valid;
    logic [7:0]  console_char;
    logic        console_ready = 1'b1;
    logic        fromhost_valid;
    logic [63:0] fromhost_data;
    logic        fromhost_ready = 1'b1;
    logic        exit_valid;
    logic [46:0] exit_code;
    logic        error;
    logic        busy;
`ifdef HTIF_STATS_EN
    logic [31:0] cmd_count;
    logic [31:0] putchar_count;
    logic [15:0] ack_stall_max;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    htif_host_responder #(.ACK_TIMEOUT(TMO), .TOHOST_W(64)) dut (
        .clock           (clock),
        .reset           (reset),
        .tohost_wr_valid (tohost_wr_valid),
        .tohost_wr_data  (tohost_wr_data),
        .tohost_wr_ready (tohost_wr_ready),
        .tohost_clear    (tohost_clear),
        .console_valid   (console_valid),
        .console_char    (console_char),
        .console_ready   (console_ready),
        .fromhost_valid  (fromhost_valid),
        .fromhost_data   (fromhost_data),
        .fromhost_ready  (fromhost_ready),
        .exit_valid      (exit_valid),
        .exit_code       (exit_code),
        .error           (error),
`ifdef HTIF_STATS_EN
        .cmd_count       (cmd_count),
        .putchar_count   (putchar_count),
        .ack_stall_max   (ack_stall_max),
`endif
        .busy            (busy)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Phase of the current command: 0 waiting, 1 classifying, 2 printing,
    // 3 acknowledging, 4 clearing tohost.
    int          m_ph = 0;
    int          m_wait = 0;
    logic [63:0] m_word = '0;
    bit          m_exit = 0;
    bit          m_err = 0;
    logic [46:0] m_code = '0;
    bit          m_known = 0;

    always @(posedge clock) begin
        if (!reset) begin
            m_ph <= 0; m_wait <= 0; m_word <= '0;
            m_exit <= 0; m_err <= 0; m_code <= '0; m_known <= 1;
        end else begin
            case (m_ph)
                0: if (tohost_wr_valid && !m_exit) begin m_word <= tohost_wr_data; m_ph <= 1; end
                1: begin
                    if (m_word[63:48] == 16'h0000 && m_word[0]) begin
                        m_exit <= 1; m_code <= m_word[47:1]; m_ph <= 4;
                    end else if (m_word[63:48] == 16'h0101) begin
                        m_ph <= 2;
                    end else begin
                        m_err <= 1; m_ph <= 4;
                    end
                end
                2: if (console_ready) begin m_ph <= 3; m_wait <= 0; end
                3: begin
                    if (fromhost_ready) m_ph <= 4;
                    else if (m_wait == TMO - 1) begin m_err <= 1; m_ph <= 4; end
                    else m_wait <= m_wait + 1;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    // ---------------- compare ----------------
    always @(negedge clock) begin
        if (m_known) begin
            cmp("tohost_wr_ready", {63'b0, tohost_wr_ready}, {63'b0, reset && m_ph == 0 && !m_exit});
            cmp("console_valid",   {63'b0, console_valid},   {63'b0, m_ph == 2});
            cmp("console_char",    {56'b0, console_char},    (m_ph == 2) ? {56'b0, m_word[7:0]} : 64'h0);
            cmp("fromhost_valid",  {63'b0, fromhost_valid},  {63'b0, m_ph == 3});
            cmp("fromhost_data",   fromhost_data,            (m_ph == 3) ? ACK_WORD : 64'h0);
            cmp("tohost_clear",    {63'b0, tohost_clear},    {63'b0, m_ph == 4});
            cmp("exit_valid",      {63'b0, exit_valid},      {63'b0, m_exit});
            cmp("exit_code",       {17'b0, exit_code},       {17'b0, m_code});
            cmp("error",           {63'b0, error},           {63'b0, m_err});
            cmp("busy",            {63'b0, busy},            {63'b0, m_ph != 0});
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic sig(input int sel);
        case (sel)
            0: return console_valid;
            1: return fromhost_valid;
            2: return tohost_clear;
            default: return exit_valid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name, input int limit);
        bit hit = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clock); #1;
            if (sig(sel)) begin hit = 1; break; end
        end
        cmp({"wait ", name}, {63'b0, hit}, 64'd1);
    endtask

    task automatic send(input logic [63:0] w);
        @(posedge clock); #1;
        tohost_wr_valid = 1'b1;
        tohost_wr_data  = w;
        @(posedge clock); #1;
        tohost_wr_valid = 1'b0;
        tohost_wr_data  = '0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        tohost_wr_valid = 1'b0;
        console_ready = 1'b1;
        fromhost_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [63:0] bad_words [4];

    initial begin
        int n;
        int acks;
        int clears;
        bad_words[0] = 64'h0000_0000_8000_1000;
        bad_words[1] = 64'h0000_0000_0000_0000;
        bad_words[2] = 64'h0102_0000_0000_0041;
        bad_words[3] = 64'h0001_0000_0000_0001;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        cmp("rst busy", {63'b0, busy}, 64'd0);
        cmp("rst ready", {63'b0, tohost_wr_ready}, 64'd0);
        cmp("rst exit_valid", {63'b0, exit_valid}, 64'd0);
        cmp("rst error", {63'b0, error}, 64'd0);
`ifdef HTIF_STATS_EN
        cmp("rst cmd_count", {32'b0, cmd_count}, 64'd0);
`endif
        reset = 1'b1;
        #1;
        cmp("ready after reset", {63'b0, tohost_wr_ready}, 64'd1);

        // Putchar with console back-pressure
        console_ready = 1'b0;
        send(64'h0101_0000_0000_0041);
        wait_for(0, "console_valid", 10);
        for (int i = 0; i < 5; i++) begin
            cmp("held console_char", {56'b0, console_char}, 64'h41);
            cmp("held console_valid", {63'b0, console_valid}, 64'd1);
            @(posedge clock); #1;
        end
        console_ready = 1'b1;
        wait_for(1, "fromhost_valid", 10);
        cmp("ack word", fromhost_data, 64'h0101_0000_0000_0000);
        wait_for(2, "clear after putchar", 10);
        cmp("putchar error", {63'b0, error}, 64'd0);

        // Putchar with immediate readies: clear 4 cycles after accept cycle
        send(64'h0101_0000_0000_005A);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            n++;
            if (tohost_clear) break;
        end
        cmp("putchar latency", n, 64'd3);

        // Ack timeout
        fromhost_ready = 1'b0;
        send(64'h0101_0000_0000_0042);
        wait_for(1, "ack before timeout", 10);
        acks = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (fromhost_valid) acks++;
            else break;
        end
        cmp("ack cycles before timeout", acks, 64'd8);
        cmp("timeout clear", {63'b0, tohost_clear}, 64'd1);
        cmp("timeout error", {63'b0, error}, 64'd1);
        @(posedge clock); #1;
        cmp("idle after timeout", {63'b0, busy}, 64'd0);
        cmp("ready after timeout", {63'b0, tohost_wr_ready}, 64'd1);
        fromhost_ready = 1'b1;
        send(64'h0101_0000_0000_0043);
        wait_for(2, "putchar after timeout", 10);
        cmp("error sticky", {63'b0, error}, 64'd1);

        // Unsupported commands
        foreach (bad_words[k]) begin
            do_reset();
            send(bad_words[k]);
            wait_for(2, "clear unsupported", 10);
            cmp("unsupported error", {63'b0, error}, 64'd1);
            cmp("unsupported exit", {63'b0, exit_valid}, 64'd0);
        end

        // Reset during CONSOLE
        do_reset();
        console_ready = 1'b0;
        send(64'h0101_0000_0000_0044);
        wait_for(0, "console before reset", 10);
        reset = 1'b0;
        @(posedge clock); #1;
        cmp("midrst busy", {63'b0, busy}, 64'd0);
        cmp("midrst console_valid", {63'b0, console_valid}, 64'd0);
        cmp("midrst console_char", {56'b0, console_char}, 64'd0);
        cmp("midrst clear", {63'b0, tohost_clear}, 64'd0);
        cmp("midrst fromhost_valid", {63'b0, fromhost_valid}, 64'd0);
        cmp("midrst ready", {63'b0, tohost_wr_ready}, 64'd0);
        cmp("midrst error", {63'b0, error}, 64'd0);
`ifdef HTIF_STATS_EN
        cmp("midrst cmd_count", {32'b0, cmd_count}, 64'd0);
        cmp("midrst putchar_count", {32'b0, putchar_count}, 64'd0);
        cmp("midrst ack_stall_max", {48'b0, ack_stall_max}, 64'd0);
`endif
        reset = 1'b1;
        console_ready = 1'b1;
        @(posedge clock); #1;
        cmp("ready after midrst", {63'b0, tohost_wr_ready}, 64'd1);

        // Exit with failure code
        send(64'h0000_0000_0000_002B);
        wait_for(3, "exit_valid fail", 10);
        cmp("exit with clear", {63'b0, tohost_clear}, 64'd1);
        cmp("exit code 21", {17'b0, exit_code}, 64'd21);
        cmp("exit fail error", {63'b0, error}, 64'd0);
        send(64'h0101_0000_0000_0045);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            cmp("halted ready", {63'b0, tohost_wr_ready}, 64'd0);
            cmp("halted busy", {63'b0, busy}, 64'd0);
        end

        // Exit pass
        do_reset();
        send(64'h0000_0000_0000_0001);
        clears = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (tohost_clear) clears++;
        end
        cmp("exit clear pulses", clears, 64'd1);
        cmp("exit pass valid", {63'b0, exit_valid}, 64'd1);
        cmp("exit pass code", {17'b0, exit_code}, 64'd0);
        cmp("exit pass ready", {63'b0, tohost_wr_ready}, 64'd0);

        @(posedge clock); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
